// File: rtl/store_pkg.sv
// Shared definitions for the row/column latch store family: loader state
// encoding, default phase lengths and the word-bit <-> (row, col) mapping.
package store_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } store_ld_state_e;

    localparam int DEF_ROWS      = 3;
    localparam int DEF_COLS      = 2;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_PULSE_CYC = 1;
    localparam int DEF_HOLD_CYC  = 1;

    // Word bit index of a cell; the readback logic uses the same mapping.
    function automatic int store_idx(input int row, input int col, input int cols = DEF_COLS);
        return row * cols + col;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/store_loader_if.sv
// Word handshake and store-side strobe bundle between a producer, the
// loader and one latch store instance.
interface store_loader_if
    import store_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
);

    logic [ROWS*COLS-1:0] in_word;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS-1:0]      dat;
    logic [COLS-1:0]      cap;
    logic                 busy;
    logic                 done;

    modport master (
        output in_word, in_valid,
        input  in_ready, dat, cap, busy, done
    );

    modport slave (
        input  in_word, in_valid,
        output in_ready, dat, cap, busy, done
    );

endinterface

// File: rtl/store_phase_timer.sv
// Loadable down-counter with a zero flag; a load of N gives N+1 cycles
// before zero is seen, which is how phase lengths are timed.
module store_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load wins over counting; the counter parks at zero when not reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/store_loader.sv
// Write-side sequencer for the latch stores: takes one word per handshake and
// programs it a column at a time with setup, strobe and hold phases.
module store_loader
    import store_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int PULSE_CYC = DEF_PULSE_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic           clk,
    input  logic           rst_n,
    store_loader_if.slave  bus
);

    localparam int PW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
    localparam logic [PW-1:0] PULSE_LD = PW'(PULSE_CYC - 1);
    localparam logic [PW-1:0] HOLD_LD  = PW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    store_ld_state_e       state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [ROWS-1:0]       dat_q, dat_d;
    logic [COLS-1:0]       cap_q, cap_d;
    logic                  done_q, done_d;
    logic [ROWS*COLS-1:0]  word_q, word_d;
    logic                  tmr_load;
    logic [PW-1:0]         tmr_val;
    logic                  tmr_zero;

    logic [ROWS-1:0]       in_col0;
    logic [ROWS-1:0]       q_cols [COLS];

    // Column 0 comes straight off the bus so dat is valid right after the handshake.
    for (genvar r = 0; r < ROWS; r++) begin : g_in_col0
        assign in_col0[r] = bus.in_word[store_idx(r, 0, COLS)];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_cols
        for (genvar r = 0; r < ROWS; r++) begin : g_rows
            assign q_cols[c][r] = word_q[store_idx(r, c, COLS)];
        end
    end

    store_phase_timer #(
        .W (PW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Every output-facing value is a registered next-state, so cap and dat leave flops.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        dat_d    = dat_q;
        cap_d    = '0;
        done_d   = 1'b0;
        word_d   = word_q;
        tmr_load = 1'b0;
        tmr_val  = SETUP_LD;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    word_d   = bus.in_word;
                    col_d    = '0;
                    dat_d    = in_col0;
                    state_d  = SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end

            SETUP: begin
                if (tmr_zero) begin
                    state_d  = STROBE;
                    cap_d    = COLS'(1) << col_q;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                end
            end

            STROBE: begin
                if (tmr_zero) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else begin
                    cap_d = cap_q;
                end
            end

            HOLD: begin
                if (tmr_zero) begin
                    if (col_q != LAST_COL) begin
                        col_d    = col_q + 1'b1;
                        dat_d    = q_cols[col_d];
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops cap asynchronously and abandons any partially written word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            dat_q   <= '0;
            cap_q   <= '0;
            done_q  <= 1'b0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dat_q   <= dat_d;
            cap_q   <= cap_d;
            done_q  <= done_d;
            word_q  <= word_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.in_ready = (state_q == IDLE);
    assign bus.dat      = dat_q;
    assign bus.cap      = cap_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_store_loader.sv
// Bench for store_loader: a 3x2 default-timing loader and a 4x5 loader with
// stretched phases, each feeding a behavioural latch store model.
module tb_store_loader;
    import store_pkg::*;

    localparam int AR = 3, AC = 2, AS = 1, AP = 1, AH = 1;
    localparam int APER = AS + AP + AH;
    localparam int BR = 4, BC = 5, BS = 2, BP = 3, BH = 2;
    localparam int BPER = BS + BP + BH;

    logic clk;
    logic rst_n;

    store_loader_if #(.ROWS(AR), .COLS(AC)) a_if ();
    store_loader_if #(.ROWS(BR), .COLS(BC)) b_if ();

    store_loader #(
        .ROWS(AR), .COLS(AC), .SETUP_CYC(AS), .PULSE_CYC(AP), .HOLD_CYC(AH)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if)
    );

    store_loader #(
        .ROWS(BR), .COLS(BC), .SETUP_CYC(BS), .PULSE_CYC(BP), .HOLD_CYC(BH)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if)
    );

    logic [AR*AC-1:0] mem_a;
    logic [BR*BC-1:0] mem_b;
    logic [AR*AC-1:0] sb_a [$];
    logic [BR*BC-1:0] sb_b [$];
    int total;
    int bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Latch store models: a cell follows its row line while its column strobe is high.
    always @(negedge clk) begin
        for (int c = 0; c < AC; c++)
            for (int r = 0; r < AR; r++)
                if (a_if.cap[c]) mem_a[r*AC + c] <= a_if.dat[r];
        for (int c = 0; c < BC; c++)
            for (int r = 0; r < BR; r++)
                if (b_if.cap[c]) mem_b[r*BC + c] <= b_if.dat[r];
    end

    function automatic logic [AR-1:0] cols_a(input logic [AR*AC-1:0] w, input int c);
        logic [AR-1:0] b;
        for (int r = 0; r < AR; r++) b[r] = w[r*AC + c];
        return b;
    endfunction

    function automatic logic [BR-1:0] cols_b(input logic [BR*BC-1:0] w, input int c);
        logic [BR-1:0] b;
        for (int r = 0; r < BR; r++) b[r] = w[r*BC + c];
        return b;
    endfunction

    function automatic logic [AC-1:0] capx_a(input int k);
        int ph;
        ph = k % APER;
        if (ph >= AS && ph < AS + AP) return AC'(1) << (k / APER);
        return '0;
    endfunction

    function automatic logic [BC-1:0] capx_b(input int k);
        int ph;
        ph = k % BPER;
        if (ph >= BS && ph < BS + BP) return BC'(1) << (k / BPER);
        return '0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        a_if.in_valid = 1'b0;
        a_if.in_word  = '0;
        b_if.in_valid = 1'b0;
        b_if.in_word  = '0;
        repeat (2) @(negedge clk);
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 1", a_if.in_ready); end
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", a_if.busy); end
        total++; if (a_if.done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b want 0", a_if.done); end
        total++; if (a_if.cap !== 2'b00) begin bad++; $display("[TB] FAIL reset_cap: got %b want 00", a_if.cap); end
        total++; if (a_if.dat !== 3'b000) begin bad++; $display("[TB] FAIL reset_dat: got %b want 000", a_if.dat); end
        total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_b_in_ready: got %b want 1", b_if.in_ready); end
        total++; if (b_if.cap !== 5'b0) begin bad++; $display("[TB] FAIL reset_b_cap: got %b want 0", b_if.cap); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_load();
        logic [5:0] w, got;
        logic [1:0] ecap;
        logic [2:0] edat;
        logic       ebusy;
        w = 6'b101101;
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL single_ready_before: got %b want 1", a_if.in_ready); end
        a_if.in_word  = w;
        a_if.in_valid = 1'b1;
        sb_a.push_back(w);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        for (int k = 0; k <= AC*APER; k++) begin
            ebusy = (k < AC*APER);
            ecap  = ebusy ? capx_a(k) : 2'b00;
            edat  = ebusy ? cols_a(w, k / APER) : cols_a(w, AC - 1);
            total++; if (a_if.cap !== ecap) begin bad++; $display("[TB] FAIL single_cap_k%0d: got %b want %b", k, a_if.cap, ecap); end
            total++; if (a_if.dat !== edat) begin bad++; $display("[TB] FAIL single_dat_k%0d: got %b want %b", k, a_if.dat, edat); end
            total++; if (a_if.busy !== ebusy) begin bad++; $display("[TB] FAIL single_busy_k%0d: got %b want %b", k, a_if.busy, ebusy); end
            total++; if (a_if.in_ready !== !ebusy) begin bad++; $display("[TB] FAIL single_ready_k%0d: got %b want %b", k, a_if.in_ready, !ebusy); end
            total++; if (a_if.done !== !ebusy) begin bad++; $display("[TB] FAIL single_done_k%0d: got %b want %b", k, a_if.done, !ebusy); end
            if (!ebusy && sb_a.size() > 0) begin
                got = sb_a.pop_front();
                total++; if (mem_a !== got) begin bad++; $display("[TB] FAIL single_store: got %b want %b", mem_a, got); end
            end
            if (ebusy) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] got;
        int busy_cnt, dones, edge_n;
        busy_cnt = 0;
        dones    = 0;
        edge_n   = -10;
        a_if.in_word  = 6'h15;
        a_if.in_valid = 1'b1;
        sb_a.push_back(6'h15);
        for (int n = 0; n < 40 && dones < 2; n++) begin
            @(negedge clk);
            if (n == 0) a_if.in_word = 6'h2A;
            if (a_if.busy) busy_cnt++;
            if (dones == 1 && n == edge_n + 1) begin
                total++; if (a_if.busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_no_gap: busy got %b want 1", a_if.busy); end
                a_if.in_valid = 1'b0;
            end
            if (a_if.done) begin
                dones++;
                got = (sb_a.size() > 0) ? sb_a.pop_front() : 6'hxx;
                total++; if (mem_a !== got) begin bad++; $display("[TB] FAIL b2b_store_%0d: got %h want %h", dones, mem_a, got); end
                if (dones == 1) begin
                    total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready_on_done: got %b want 1", a_if.in_ready); end
                    sb_a.push_back(6'h2A);
                    edge_n = n;
                end
            end
        end
        total++; if (dones != 2) begin bad++; $display("[TB] FAIL b2b_timeout: dones got %0d want 2", dones); end
        total++; if (busy_cnt != 2*AC*APER) begin bad++; $display("[TB] FAIL b2b_busy_cycles: got %0d want %0d", busy_cnt, 2*AC*APER); end
        total++; if (mem_a !== 6'h2A) begin bad++; $display("[TB] FAIL b2b_final_store: got %h want 2a", mem_a); end
    endtask

    task automatic test_busy_ignore();
        logic [5:0] got;
        bit seen;
        seen = 0;
        a_if.in_word  = 6'h0C;
        a_if.in_valid = 1'b1;
        sb_a.push_back(6'h0C);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (a_if.done) begin
                seen = 1;
                got = (sb_a.size() > 0) ? sb_a.pop_front() : 6'hxx;
                total++; if (mem_a !== got) begin bad++; $display("[TB] FAIL ignore_store: got %h want %h", mem_a, got); end
            end else begin
                if (n == 1) begin
                    total++; if (a_if.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL ignore_ready_busy: got %b want 0", a_if.in_ready); end
                end
                a_if.in_word  = 6'($urandom);
                a_if.in_valid = (n < 4) ? n[0] : 1'b0;
            end
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL ignore_timeout: done never seen"); end
        @(negedge clk);
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("[TB] FAIL ignore_no_extra_load: busy got %b want 0", a_if.busy); end
    endtask

    task automatic test_async_reset();
        logic [5:0] got;
        bit hit, seen;
        int busy_cnt;
        hit = 0;
        seen = 0;
        busy_cnt = 0;
        a_if.in_word  = 6'h2D;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            if (a_if.cap[1]) hit = 1;
            else @(negedge clk);
        end
        total++; if (!hit) begin bad++; $display("[TB] FAIL areset_reach_strobe1: cap[1] never high"); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (a_if.cap !== 2'b00) begin bad++; $display("[TB] FAIL areset_cap_async: got %b want 00", a_if.cap); end
        total++; if (a_if.dat !== 3'b000) begin bad++; $display("[TB] FAIL areset_dat: got %b want 000", a_if.dat); end
        total++; if (a_if.busy !== 1'b0) begin bad++; $display("[TB] FAIL areset_busy: got %b want 0", a_if.busy); end
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL areset_ready: got %b want 1", a_if.in_ready); end
        total++; if (a_if.done !== 1'b0) begin bad++; $display("[TB] FAIL areset_done: got %b want 0", a_if.done); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (a_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL areset_ready_after: got %b want 1", a_if.in_ready); end
        a_if.in_word  = 6'h3F;
        a_if.in_valid = 1'b1;
        sb_a.push_back(6'h3F);
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            a_if.in_valid = 1'b0;
            if (a_if.busy) busy_cnt++;
            if (a_if.done) begin
                seen = 1;
                got = (sb_a.size() > 0) ? sb_a.pop_front() : 6'hxx;
                total++; if (mem_a !== got) begin bad++; $display("[TB] FAIL areset_fresh_store: got %h want %h", mem_a, got); end
            end
        end
        total++; if (!seen) begin bad++; $display("[TB] FAIL areset_fresh_timeout: done never seen"); end
        total++; if (busy_cnt != AC*APER) begin bad++; $display("[TB] FAIL areset_fresh_len: got %0d want %0d", busy_cnt, AC*APER); end
    endtask

    task automatic test_stretched();
        logic [BR*BC-1:0] w, got;
        logic [BC-1:0]    ecap, prev_cap;
        logic [BR-1:0]    edat, prev_dat;
        logic             ebusy;
        int capcyc, busy_cnt;
        bit stable_ok;
        w = 20'hA5C3E;
        capcyc = 0;
        busy_cnt = 0;
        stable_ok = 1;
        total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stretch_ready_before: got %b want 1", b_if.in_ready); end
        b_if.in_word  = w;
        b_if.in_valid = 1'b1;
        sb_b.push_back(w);
        @(negedge clk);
        b_if.in_valid = 1'b0;
        prev_cap = '0;
        prev_dat = b_if.dat;
        for (int k = 0; k <= BC*BPER; k++) begin
            ebusy = (k < BC*BPER);
            ecap  = ebusy ? capx_b(k) : '0;
            edat  = ebusy ? cols_b(w, k / BPER) : cols_b(w, BC - 1);
            total++; if (b_if.cap !== ecap) begin bad++; $display("[TB] FAIL stretch_cap_k%0d: got %b want %b", k, b_if.cap, ecap); end
            total++; if (b_if.dat !== edat) begin bad++; $display("[TB] FAIL stretch_dat_k%0d: got %b want %b", k, b_if.dat, edat); end
            total++; if (b_if.busy !== ebusy) begin bad++; $display("[TB] FAIL stretch_busy_k%0d: got %b want %b", k, b_if.busy, ebusy); end
            total++; if (b_if.done !== !ebusy) begin bad++; $display("[TB] FAIL stretch_done_k%0d: got %b want %b", k, b_if.done, !ebusy); end
            if (b_if.cap != '0) capcyc++;
            if (b_if.busy) busy_cnt++;
            if ((b_if.cap != '0 || prev_cap != '0) && b_if.dat !== prev_dat) stable_ok = 0;
            prev_cap = b_if.cap;
            prev_dat = b_if.dat;
            if (!ebusy && sb_b.size() > 0) begin
                got = sb_b.pop_front();
                total++; if (mem_b !== got) begin bad++; $display("[TB] FAIL stretch_store: got %h want %h", mem_b, got); end
            end
            if (ebusy) @(negedge clk);
        end
        total++; if (capcyc != BC*BP) begin bad++; $display("[TB] FAIL stretch_pulse_cycles: got %0d want %0d", capcyc, BC*BP); end
        total++; if (busy_cnt != BC*BPER) begin bad++; $display("[TB] FAIL stretch_busy_len: got %0d want %0d", busy_cnt, BC*BPER); end
        total++; if (!stable_ok) begin bad++; $display("[TB] FAIL stretch_dat_stable: dat moved around a strobe"); end
    endtask

    task automatic test_random_onehot();
        logic [BR*BC-1:0] w, got;
        logic [BC-1:0]    prev_cap;
        logic [BR-1:0]    prev_dat;
        bit oh_ok, st_ok, seen;
        for (int i = 0; i < 1000; i++) begin
            w = 20'($urandom);
            total++; if (b_if.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rand_ready_%0d: got %b want 1", i, b_if.in_ready); end
            b_if.in_word  = w;
            b_if.in_valid = 1'b1;
            sb_b.push_back(w);
            @(negedge clk);
            b_if.in_valid = 1'b0;
            oh_ok = 1;
            st_ok = 1;
            seen  = 0;
            prev_cap = '0;
            prev_dat = b_if.dat;
            for (int n = 0; n < 60 && !seen; n++) begin
                if (!$onehot0(b_if.cap)) oh_ok = 0;
                if ((b_if.cap != '0 || prev_cap != '0) && b_if.dat !== prev_dat) st_ok = 0;
                prev_cap = b_if.cap;
                prev_dat = b_if.dat;
                if (b_if.done) begin
                    seen = 1;
                    got = (sb_b.size() > 0) ? sb_b.pop_front() : 'x;
                    total++; if (mem_b !== got) begin bad++; $display("[TB] FAIL rand_store_%0d: got %h want %h", i, mem_b, got); end
                end else begin
                    @(negedge clk);
                end
            end
            total++; if (!seen) begin bad++; $display("[TB] FAIL rand_timeout_%0d: done never seen", i); end
            total++; if (!oh_ok) begin bad++; $display("[TB] FAIL rand_onehot_%0d: cap had more than one bit high", i); end
            total++; if (!st_ok) begin bad++; $display("[TB] FAIL rand_dat_stable_%0d: dat moved around a strobe", i); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        $display("[TB] starting store_loader bench");
        test_reset();
        test_single_load();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
        test_stretched();
        test_random_onehot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/store_loader.md
# store_loader

Write-side sequencer for the row/column latch storage arrays (`store_3x2` and siblings). It accepts one full storage word over a valid/ready handshake and drives the array's row data lines `dat` and column capture strobes `cap`. It programs one column at a time with explicit setup, strobe and hold phases, so latch timing is met by construction. It sits between the configuration/bus logic and each store instance.

## Interface
Parameters:
- `ROWS`, default 3: number of rows (data lines) in the target store.
- `COLS`, default 2: number of columns (capture strobes) in the target store.
- `SETUP_CYC`, default 1: cycles `dat` is stable before `cap` rises; must be ≥1.
- `PULSE_CYC`, default 1: cycles `cap` is high; must be ≥1.
- `HOLD_CYC`, default 1: cycles `dat` is held after `cap` falls; must be ≥1.

Ports:
- `clk`, input, 1: single clock; all state is updated on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_word`, input, ROWS*COLS: word to store. Bit k maps to row k/COLS, column k%COLS, which is store output index k.
- `in_valid`, input, 1: `in_word` is valid.
- `in_ready`, output, 1: loader is idle and can accept a word.
- `dat`, output, ROWS: row data lines to the store.
- `cap`, output, COLS: column capture strobes to the store; at most one bit is high at a time.
- `busy`, output, 1: a load is in progress.
- `done`, output, 1: one-cycle pulse when the last column has completed its hold phase.

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD. There is one phase down-counter and one column index `col` (0..COLS-1).
- **Reset values:** state=IDLE, `col`=0, `dat`=0, `cap`=0, `in_ready`=1, `busy`=0, `done`=0.
- **Word capture:** `in_word` is registered internally when `in_valid && in_ready` at a clock edge. Later changes on `in_word` have no effect.
- **IDLE:**
  - `in_ready`=1, `cap`=0, and `dat` keeps its last value.
  - On handshake: go to SETUP, set `col`=0, drive `dat[r]` = word[r*COLS+0].
- **SETUP:**
  - `cap`=0 and `dat` is stable.
  - Lasts SETUP_CYC cycles, then go to STROBE.
- **STROBE:**
  - `cap[col]`=1 and all other `cap` bits are 0; `dat` is unchanged.
  - Lasts PULSE_CYC cycles, then go to HOLD.
- **HOLD:**
  - `cap`=0 and `dat` is unchanged.
  - Lasts HOLD_CYC cycles.
  - If `col`<COLS-1: increment `col`, load `dat` with the next column's bits, go to SETUP.
  - Otherwise: go to IDLE and assert `done` for that one cycle.
- **Glitch-free outputs:** `cap` and `dat` come directly from flops, with no combinational decode on the outputs.
- **Status outputs:** `busy` = (state != IDLE). `in_ready` = !busy.
- **Mid-operation reset:** `cap` drops to 0 asynchronously and the sequence is abandoned. The store contents are undefined for partially written columns; no recovery is attempted.
- **`in_valid` while busy:** ignored. The word is neither stored nor dropped silently, because the producer must hold `in_valid` until it sees `in_ready`.

## Timing
- **Handshake:** edge E0 accepts the word. After E0 the block is in SETUP with `col`=0 and `dat` driven.
- **Per-column period:** P = SETUP_CYC + PULSE_CYC + HOLD_CYC cycles.
- **Per-column strobe:** `cap[c]` is high during cycles [E0 + c*P + SETUP_CYC, + PULSE_CYC).
- **Load length:** `busy` is high for exactly COLS*P cycles. With defaults that is 6 cycles.
- **Completion:** `done` and `in_ready` rise on the same edge, at E0 + COLS*P.
- **Back-to-back loads:** a new word can be accepted on the edge where `done` is high. There are zero dead cycles between loads.
- **Data stability:** `dat` changes only on the edge that enters SETUP, never while any `cap` bit is high or during HOLD.

## Structure
- **Shared package `store_pkg`:**
  - State enum `store_ld_state_e` (IDLE, SETUP, STROBE, HOLD).
  - Default phase-length constants.
  - A function `store_idx(row, col)` = row*COLS+col, shared with the store readback logic.
- **Phase counter width:** $clog2(max(SETUP_CYC, PULSE_CYC, HOLD_CYC)+1).
- **Column counter width:** $clog2(COLS), minimum 1.
- **Sub-module:** one, `store_phase_timer`. It is a loadable down-counter with a `zero` flag, reused by the future readback scanner.

## Test plan
- **Single load, defaults:** `in_word`=6'b101101 → `cap` sequence is `cap[0]` high in cycle 2 and `cap[1]` high in cycle 5. `dat`=3'b011 (rows 0..2 = bits 0,2,4) then 3'b110. `done` pulses at cycle 6. The attached `store_3x2` model reads back 6'b101101.
- **Back-to-back:** hold `in_valid` with words 6'h15 then 6'h2A → the second handshake is on the `done` edge, and there are 12 busy cycles total with no gap. The store ends at 6'h2A.
- **Stretched phases:** SETUP_CYC=2, PULSE_CYC=3, HOLD_CYC=2, COLS=2 → `busy` is high for 14 cycles, each `cap` pulse is 3 cycles wide, and `dat` never changes while `cap`≠0 (assertion).
- **Busy ignore:** change `in_word` and toggle `in_valid` during a load → the stored word equals the value captured at the handshake.
- **Async reset mid-load:** drop `rst_n` during STROBE of column 1 → `cap`=0 immediately (before the next edge) and all outputs take their reset values. After release, `in_ready`=1 and a fresh load of 6'h3F completes in 6 cycles.
- **One-hot check:** random words over 1000 loads with ROWS=4, COLS=5 → `$onehot0(cap)` always holds and every readback matches.
